// File: rtl/muldiv_ctrl.sv
// RV64M multiply/divide sequencer: shift-add multiplier, restoring divider, RV64 corner cases.
// Optional MULDIV_FAST_MUL_EN: MUL/MULW use a single-cycle multiply on the fast path.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_MUL = 4'd0, OP_DIV = 4'd1, OP_DIVU = 4'd2, OP_REM = 4'd3, OP_REMU = 4'd4,
    OP_MULW = 4'd5, OP_DIVW = 4'd6, OP_DIVUW = 4'd7, OP_REMW = 4'd8, OP_REMUW = 4'd9
  } op_t;

  function automatic logic [63:0] fix_w(input logic is_w, input logic [63:0] v);
    return is_w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  state_t      r_state;
  logic        r_ready, r_busy, r_done;
  logic [63:0] r_result;
  logic [6:0]  r_cnt;
  logic [63:0] r_acc, r_rem, r_a, r_b;
  logic        r_is_mul, r_is_rem, r_is_w, r_neg_q, r_neg_r;

  logic        w_is_mul, w_is_rem, w_is_w, w_signed, w_legal;
  logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic        w_a_neg, w_b_neg, w_div0, w_ovf, w_fast;
  logic [63:0] w_fast_raw, w_fast_res;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_rem = 1'b0;
    w_is_w   = 1'b0;
    w_signed = 1'b0;
    w_legal  = 1'b1;
    case (req_op)
      OP_MUL:   w_is_mul = 1'b1;
      OP_DIV:   w_signed = 1'b1;
      OP_DIVU:  ;
      OP_REM:   begin w_is_rem = 1'b1; w_signed = 1'b1; end
      OP_REMU:  w_is_rem = 1'b1;
      OP_MULW:  begin w_is_mul = 1'b1; w_is_w = 1'b1; end
      OP_DIVW:  begin w_is_w = 1'b1; w_signed = 1'b1; end
      OP_DIVUW: w_is_w = 1'b1;
      OP_REMW:  begin w_is_w = 1'b1; w_is_rem = 1'b1; w_signed = 1'b1; end
      OP_REMUW: begin w_is_w = 1'b1; w_is_rem = 1'b1; end
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_a_ext = req_a;
    w_b_ext = req_b;
    if (w_is_w) begin
      w_a_ext = w_signed ? {{32{req_a[31]}}, req_a[31:0]} : {32'b0, req_a[31:0]};
      w_b_ext = w_signed ? {{32{req_b[31]}}, req_b[31:0]} : {32'b0, req_b[31:0]};
    end
    w_a_neg = w_signed & w_a_ext[63];
    w_b_neg = w_signed & w_b_ext[63];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = w_signed && (w_b_ext == '1) &&
              (w_a_ext == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

  always_comb begin
    w_fast     = 1'b1;
    w_fast_raw = '0;
    if (!w_legal) begin
      w_fast_raw = '0;
    end else if (w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
      w_fast_raw = req_a * req_b;
`else
      w_fast = 1'b0;
`endif
    end else if (w_div0) begin
      w_fast_raw = w_is_rem ? w_a_ext : '1;
    end else if (w_ovf) begin
      w_fast_raw = w_is_rem ? '0 : w_a_ext;
    end else begin
      w_fast = 1'b0;
    end
    w_fast_res = fix_w(w_is_w & w_legal, w_fast_raw);
  end

  // W divides park the 32-bit dividend in the upper half so the divider always consumes from bit 63.
  logic [64:0] w_shift, w_diff;
  logic        w_sub_ok;
  logic [63:0] w_rem_nx, w_quo_nx, w_prod_nx, w_q, w_q_s, w_r_s, w_iter_res;

  always_comb begin
    w_shift    = {r_rem, r_acc[63]};
    w_diff     = w_shift - {1'b0, r_b};
    w_sub_ok   = ~w_diff[64];
    w_rem_nx   = w_sub_ok ? w_diff[63:0] : w_shift[63:0];
    w_quo_nx   = {r_acc[62:0], w_sub_ok};
    w_prod_nx  = r_acc + (r_b[0] ? r_a : '0);
    w_q        = r_is_w ? {32'b0, w_quo_nx[31:0]} : w_quo_nx;
    w_q_s      = r_neg_q ? -w_q : w_q;
    w_r_s      = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_iter_res = fix_w(r_is_w, r_is_mul ? w_prod_nx : (r_is_rem ? w_r_s : w_q_s));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_is_w   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_is_mul <= w_is_mul;
            r_is_rem <= w_is_rem;
            r_is_w   <= w_is_w;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rem    <= '0;
            r_a      <= w_a_ext;
            r_b      <= w_is_mul ? w_b_ext : w_b_mag;
            r_acc    <= w_is_mul ? '0 : (w_is_w ? {w_a_mag[31:0], 32'b0} : w_a_mag);
            if (w_fast) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_fast_res;
              r_cnt    <= '0;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= w_is_w ? 7'd32 : 7'd64;
            end
          end
        end
        S_RUN: begin
          if (r_is_mul) begin
            r_acc <= w_prod_nx;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_quo_nx;
            r_rem <= w_rem_nx;
          end
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_iter_res;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done & ~flush;
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        busy, done;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FASTMUL = 1'b1;
`else
  localparam bit FASTMUL = 1'b0;
`endif

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain signed/unsigned arithmetic.
  function automatic void ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output int lat);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] a32, b32, r32;
    bit          fast, w;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    fast = 0; w = 0; r = '0; r32 = '0;
    case (op)
      4'd0: begin r = a * b; fast = FASTMUL; end
      4'd1: if (b == 0) begin r = '1; fast = 1; end
            else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; fast = 1; end
            else r = sa / sb;
      4'd2: if (b == 0) begin r = '1; fast = 1; end else r = a / b;
      4'd3: if (b == 0) begin r = a; fast = 1; end
            else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = '0; fast = 1; end
            else r = sa % sb;
      4'd4: if (b == 0) begin r = a; fast = 1; end else r = a % b;
      4'd5: begin w = 1; r32 = a32 * b32; fast = FASTMUL; end
      4'd6: begin w = 1;
              if (b32 == 0) begin r32 = '1; fast = 1; end
              else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = a32; fast = 1; end
              else r32 = sa32 / sb32;
            end
      4'd7: begin w = 1; if (b32 == 0) begin r32 = '1; fast = 1; end else r32 = a32 / b32; end
      4'd8: begin w = 1;
              if (b32 == 0) begin r32 = a32; fast = 1; end
              else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = '0; fast = 1; end
              else r32 = sa32 % sb32;
            end
      4'd9: begin w = 1; if (b32 == 0) begin r32 = a32; fast = 1; end else r32 = a32 % b32; end
      default: begin r = '0; fast = 1; end
    endcase
    if (w) r = {{32{r32[31]}}, r32};
    lat = fast ? 1 : (w ? 33 : 65);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    int lat, seen;
    ref_model(op, a, b, exp, lat);
    @(negedge clk);
    check($sformatf("ready op%0d", op), req_ready, 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    seen = 0;
    for (int c = 1; c <= 80 && seen == 0; c++) begin
      @(negedge clk);
      if (c == 1) check($sformatf("busy op%0d", op), busy, 1);
      if (done) seen = c;
    end
    check($sformatf("latency op%0d", op), seen, lat);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), result, exp);
    @(negedge clk);
    check($sformatf("pulse op%0d", op), done, 0);
    check($sformatf("busy_fall op%0d", op), busy, 0);
    check($sformatf("hold op%0d", op), result, exp);
  endtask

  // Start op, wait 'after' cycles, then abort with flush (use_reset=0) or reset (use_reset=1).
  task automatic abort_run(input bit use_reset, input int after);
    logic [63:0] prev;
    prev = result;
    @(negedge clk);
    req_valid = 1; req_op = 4'd2; req_a = 64'd1000; req_b = 64'd7;
    @(posedge clk);
    #1 req_valid = 0;
    for (int c = 1; c < after; c++) @(negedge clk);
    @(negedge clk);
    if (use_reset) begin
      reset = 1; #1;
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      @(negedge clk); reset = 0;
    end else begin
      flush = 1;
      @(negedge clk); flush = 0;
      check("flush_ready", req_ready, 1);
      check("flush_busy", busy, 0);
      check("flush_result", result, prev);
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) check("abort_no_done", done, 0);
    end
    check("abort_idle_busy", busy, 0);
    run_op(4'd0, 64'd3, 64'd4);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    reset = 1; req_valid = 0; req_op = '0; req_a = '0; req_b = '0; flush = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    reset = 0;

    run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd2, 64'd100, 64'd0);
    run_op(4'd3, 64'd100, 64'd0);
    run_op(4'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd1, -64'sd17, 64'd5);
    run_op(4'd3, -64'sd17, 64'd5);
    run_op(4'd4, 64'd17, 64'd5);
    run_op(4'd7, 64'hFFFF_FFFF, 64'd1);
    run_op(4'd6, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF);
    run_op(4'd9, 64'h0000_0000_FFFF_FFF0, 64'd0);
    run_op(4'd12, 64'd5, 64'd3);
    run_op(4'd5, 64'h0000_0001_0001_0001, 64'hFFFF_FFFF_0001_0000);

    abort_run(1'b0, 10);
    abort_run(1'b1, 10);

    // Flush alongside a request in IDLE must block acceptance.
    @(negedge clk);
    req_valid = 1; req_op = 4'd2; req_a = 64'd9; req_b = 64'd0; flush = 1;
    @(negedge clk);
    req_valid = 0; flush = 0;
    check("flush_req_busy", busy, 0);
    check("flush_req_ready", req_ready, 1);
    check("flush_req_done", done, 0);

    // Flush during the DONE cycle of a fast-path op masks done.
    @(negedge clk);
    req_valid = 1; req_op = 4'd2; req_a = 64'd9; req_b = 64'd0;
    @(posedge clk);
    #1 req_valid = 0; flush = 1;
    @(negedge clk);
    check("flush_done_masked", done, 0);
    @(negedge clk);
    flush = 0;
    check("flush_done_idle", busy, 0);
    check("flush_done_ready", req_ready, 1);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        1: b = '0;
        2: begin a = 64'h8000_0000_0000_0000; b = '1; end
        3: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        4: b = $urandom_range(0, 1) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle RV64M multiply/divide sequencer alongside the execute stage. Execute hands MUL/DIV/REM operations to this block and holds the pipeline stalled until `done`. The block owns a shift-add multiplier and a restoring divider and their state machine, iteration counter, operand sign fix-up and RV64 corner cases.

## Interface
- No parameters; data width fixed at 64 (`u64`/`word_t`).
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  execute presents an M-extension op
- `req_ready`  out  1  high only in IDLE; acceptance = `req_valid & req_ready & ~flush`
- `req_op`  in  4  0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5 MULW, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10–15 illegal
- `req_a`  in  64  rs1 value
- `req_b`  in  64  rs2 value
- `flush`  in  1  abort any in-flight op
- `busy`  out  1  state is RUN or DONE; execute ORs this into its stall
- `done`  out  1  one-cycle result strobe
- `result`  out  64  final value; valid when `done`, held until next acceptance

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: `req_ready=1`. On acceptance, latch op and operands and select an iteration count N: 64 for 64-bit ops, 32 for W ops. Then:
  - fast-path ops go straight to DONE;
  - all others go to RUN with the counter loaded with N.
- RUN: one shift-add or one restoring-subtract step per cycle; the counter decrements; on the last step go to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Fast-path cases (result computed at acceptance):
  - divide by zero: DIV*/DIVU* give all ones; REM* give the dividend;
  - signed overflow (most-negative ÷ −1): DIV/DIVW give the dividend; REM/REMW give 0;
  - illegal op: result 0.
- Signed divide: operate on magnitudes. Quotient is negated when operand signs differ. Remainder takes the dividend's sign.
- MUL/MULW keep the low 64 bits of the product.
- W ops:
  - use the low 32 bits of each operand, sign-extended for signed ops and zero-extended for unsigned ops;
  - the final result is always sign-extended from bit 31, including DIVUW and REMUW.
- Overflow and zero detection for W ops uses the 32-bit values.
- `flush` in any state forces IDLE next cycle. It masks `done` in the same cycle and blocks acceptance in the same cycle. `result` is left unchanged.

## Timing
- Reset values: state IDLE, `req_ready=1`, `busy=0`, `done=0`, `result=0`, counter 0.
- Accept on edge k:
  - iterative ops: RUN occupies cycles k+1 … k+N; `done` is high in cycle k+N+1 (latency 65 for 64-bit, 33 for W);
  - fast-path ops: `done` is high in cycle k+1.
- The earliest next acceptance is the cycle after `done`; there is no back-to-back overlap.
- `busy` rises in cycle k+1 and falls in the cycle after `done`.
- `req_*` inputs are don't-care outside IDLE.
- Reset asserted mid-operation: immediate return to reset values, no `done`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL and MULW use a single-cycle `*` and take the fast path (`done` at k+1);
  - divide paths are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: MUL and MULW use the iterative shift-add path (N cycles in RUN).

## Test plan
- MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD.
  - Macro off: `result`=0xFFFF_FFFF_FFFF_FFEB with `done` 65 cycles after accept.
  - Macro on: the same `result` one cycle after accept.
- DIVU a=100, b=0 → 0xFFFF_FFFF_FFFF_FFFF at k+1. REM a=100, b=0 → 100 at k+1.
- DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000 at k+1. REM with the same operands → 0.
- Signed, unsigned and W division:
  - DIV a=−17, b=5 → −3 (0xFFFF_FFFF_FFFF_FFFD) at k+65;
  - REM a=−17, b=5 → −2 (0xFFFF_FFFF_FFFF_FFFE);
  - REMU a=17, b=5 → 2;
  - DIVUW a=0xFFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF at k+33.
- Flush and reset during RUN:
  - start DIVU, assert `flush` 10 cycles after accept: no `done`, `req_ready=1` next cycle; a MUL 3×4 then accepts and returns 12;
  - same sequence with `reset` instead of `flush`: all outputs return to reset values asynchronously.
- Flush coincident with a request: `flush=1` and `req_valid=1` together in IDLE → not accepted. Flush coinciding with the DONE cycle → `done` stays 0.
